pulse_capture: RTL
==================

// Module: pulse_capture
// PURPOSE
//  Measures active width and period of a digitally filtered input, counted in refclk ticks.
//  Sits directly downstream of the digital filter and consumes its data_out/act_edge/inact_edge.
//  Presents results through a valid/ack handshake to the bus register block.
//  Flags overrun and counter saturation.
// PARAMETERS
//  BW      16  width of tick counter and result fields
// PORTS
//  clk         in   1   global clock
//  rst_n       in   1   reset: synchronous and active-low
//  refclk      in   1   1-clk tick enable, from refclk divider
//  enable      in   1   measurement enable; 0 forces IDLE
//  act_edge    in   1   1-clk pulse, filtered signal entered active level
//  inact_edge  in   1   1-clk pulse, filtered signal entered inactive level
//  cap_ack     in   1   consumer accepts current result
//  high_width  out  BW  ticks from act_edge to inact_edge
//  period      out  BW  ticks from act_edge to next act_edge
//  cap_valid   out  1   result pair valid; held until cap_ack
//  overrun     out  1   sticky: new capture while cap_valid=1 and no cap_ack
//  cap_sat     out  1   counter saturated during the reported period
//  timeout     out  1   1-clk pulse on saturation abort (PCAP_TIMEOUT_EN only, else 0)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, every output=0.
//  Free-running saturating counter: cnt+1 on each refclk while state!=IDLE; stops at all-ones, sets sat_q.
//  Edge cycle: cnt loads 0 (or captures); a refclk in the same cycle is not counted.
//  States:
//   IDLE:       act_edge -> MEAS_ACT, cnt=0, sat_q=0. inact_edge ignored.
//   MEAS_ACT:   inact_edge -> hw_q=cnt, MEAS_INACT.
//               act_edge (missed inactive) -> restart: cnt=0, stay.
//   MEAS_INACT: act_edge -> capture; cnt=0, sat_q=0, MEAS_ACT.
//               inact_edge ignored.
//  Capture registers next clk: period=cnt, high_width=hw_q, cap_sat=sat_q, cap_valid=1.
//   Latency 1 clk after the act_edge cycle.
//  cap_ack with cap_valid=1: cap_valid=0 next clk.
//   Results hold until the next capture.
//  Simultaneous act_edge+inact_edge: act_edge wins; inact_edge dropped.
//  Capture while cap_valid=1:
//   - with cap_ack same cycle: data updates, cap_valid stays 1, no overrun.
//   - without cap_ack: data updates, overrun=1.
//  overrun clears only on rst_n or on cap_ack.
//  enable=0: next clk IDLE, cnt=0, sat_q=0; cap_valid/results/overrun retained.
//  Reset mid-measurement: everything cleared as at reset; partial measurement discarded.
// CONFIGURATION
//  PCAP_TIMEOUT_EN defined:
//   - saturation in MEAS_ACT/MEAS_INACT -> timeout=1 for one clk, state=IDLE, no capture.
//  PCAP_TIMEOUT_EN undefined:
//   - counter holds at all-ones and measurement continues; reported via cap_sat.
//   - timeout tied 0.
// STRUCTURE
//  pcap_defs.vh (shared): state encodings PCAP_IDLE=2'd0, PCAP_MEAS_ACT=2'd1, PCAP_MEAS_INACT=2'd2.
//   Also the default BW.
//  Sub-module pcap_counter:
//   - BW-bit saturating tick counter with clr/en.
//   - sat flag output.
// TESTING
//  (BW=8 unless noted; bench drives refclk every 3 clk, never in an edge cycle)
//  1 Reset held 2 clk -> all outputs 0; state IDLE.
//  2 Basic measurement:
//     act, 5 ticks, inact, 7 ticks, act -> next clk high_width=5, period=12, cap_valid=1.
//     cap_ack -> cap_valid=0.
//  3 Second capture without ack -> overrun=1, fields updated.
//     Ack in same cycle as capture -> overrun stays 0.
//  4 act then 300 ticks, no edge:
//     defined -> timeout pulse at tick 255, IDLE, cap_valid=0.
//     undefined -> next act gives period=255, cap_sat=1.
//  5 enable=0 mid MEAS_INACT, then act -> no capture; re-enable, full cycle -> correct result.
//  6 act_edge and inact_edge in same clk while in MEAS_ACT -> treated as act: cnt=0, no hw_q update.

Source files
------------

// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse_capture block.
//   PCAP_BW_DEFAULT : default width of the tick counter and result fields
//   pcap_state_e    : measurement FSM state encodings
package pulse_capture_pkg;

    localparam int unsigned PCAP_BW_DEFAULT = 16;

    typedef enum logic [1:0] {
        PCAP_IDLE       = 2'd0,
        PCAP_MEAS_ACT   = 2'd1,
        PCAP_MEAS_INACT = 2'd2
    } pcap_state_e;

endpackage

// File: rtl/pulse_capture_if.sv
// Result/handshake bus between pulse_capture and the bus register block.
//   cap_ack    : consumer accepts current result
//   high_width : ticks from act_edge to inact_edge
//   period     : ticks from act_edge to next act_edge
//   cap_valid  : result pair valid, held until cap_ack
//   overrun    : sticky, capture while unacknowledged result pending
//   cap_sat    : counter saturated during the reported period
//   timeout    : 1-clk pulse on saturation abort (PCAP_TIMEOUT_EN builds only)
// Modports: master = pulse_capture, slave = consumer.
interface pulse_capture_if
    import pulse_capture_pkg::*;
#(
    parameter int unsigned BW = PCAP_BW_DEFAULT
) ();

    logic          cap_ack;
    logic [BW-1:0] high_width;
    logic [BW-1:0] period;
    logic          cap_valid;
    logic          overrun;
    logic          cap_sat;
    logic          timeout;

    modport master (
        input  cap_ack,
        output high_width, period, cap_valid, overrun, cap_sat, timeout
    );

    modport slave (
        output cap_ack,
        input  high_width, period, cap_valid, overrun, cap_sat, timeout
    );

endinterface

// File: rtl/pulse_capture_counter.sv
// pcap_counter: BW-bit saturating tick counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : load 0 and clear sat (has priority over en)
//   en         : advance by one unless already all-ones
//   cnt        : current count
//   sat        : set when the count reaches all-ones, cleared by clr
module pcap_counter
    import pulse_capture_pkg::*;
#(
    parameter int unsigned BW = PCAP_BW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] cnt,
    output logic          sat
);

    localparam logic [BW-1:0] CNT_MAX    = '1;
    localparam logic [BW-1:0] CNT_PRESAT = {{(BW-1){1'b1}}, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRESAT)
                sat <= 1'b1;
        end
    end

endmodule

// File: rtl/pulse_capture.sv
// pulse_capture: measures active width and period of a filtered input in
// refclk ticks and hands the result pair to the register block.
//   clk, rst_n  : clock, synchronous active-low reset
//   refclk      : 1-clk tick enable
//   enable      : measurement enable, 0 forces IDLE
//   act_edge    : filtered signal entered active level (1-clk pulse)
//   inact_edge  : filtered signal entered inactive level (1-clk pulse)
//   bus         : result/handshake bus (pulse_capture_if.master)
// Build option: PCAP_TIMEOUT_EN -- saturation aborts the measurement with a
// one-clk timeout pulse; otherwise the counter holds and cap_sat reports it.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int unsigned BW = PCAP_BW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refclk,
    input  logic             enable,
    input  logic             act_edge,
    input  logic             inact_edge,
    pulse_capture_if.master  bus
);

    pcap_state_e   state, state_n;
    logic [BW-1:0] cnt;
    logic [BW-1:0] hw_q;
    logic          sat;
    logic          cnt_clr;
    logic          cnt_en;
    logic          hw_load;
    logic          capture;

    // Ticks are not counted in a cycle that carries a handled edge.
    assign cnt_en = refclk && enable && (state != PCAP_IDLE) && !act_edge
                    && !((state == PCAP_MEAS_ACT) && inact_edge);

    pcap_counter #(.BW(BW)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .sat   (sat)
    );

`ifdef PCAP_TIMEOUT_EN
    localparam logic [BW-1:0] CNT_PRESAT = {{(BW-1){1'b1}}, 1'b0};
    logic timeout_n;
    logic sat_set;

    // Counter reaches all-ones at the coming edge.
    assign sat_set = cnt_en && (cnt == CNT_PRESAT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= PCAP_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        hw_load = 1'b0;
        capture = 1'b0;
`ifdef PCAP_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        if (!enable) begin
            state_n = PCAP_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                PCAP_IDLE: begin
                    cnt_clr = 1'b1;
                    if (act_edge)
                        state_n = PCAP_MEAS_ACT;
                end
                PCAP_MEAS_ACT: begin
                    // act_edge wins over a simultaneous inact_edge.
                    if (act_edge) begin
                        cnt_clr = 1'b1;
                    end else if (inact_edge) begin
                        hw_load = 1'b1;
                        state_n = PCAP_MEAS_INACT;
                    end
                end
                PCAP_MEAS_INACT: begin
                    if (act_edge) begin
                        capture = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = PCAP_MEAS_ACT;
                    end
                end
                default: begin
                    state_n = PCAP_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
`ifdef PCAP_TIMEOUT_EN
            if (sat_set) begin
                state_n   = PCAP_IDLE;
                timeout_n = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hw_q           <= '0;
            bus.high_width <= '0;
            bus.period     <= '0;
            bus.cap_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.cap_sat    <= 1'b0;
        end else begin
            if (hw_load)
                hw_q <= cnt;
            if (capture) begin
                bus.period     <= cnt;
                bus.high_width <= hw_q;
                bus.cap_sat    <= sat;
                bus.cap_valid  <= 1'b1;
                // An ack in the capture cycle consumes the old pair.
                if (bus.cap_ack)
                    bus.overrun <= 1'b0;
                else if (bus.cap_valid)
                    bus.overrun <= 1'b1;
            end else if (bus.cap_ack) begin
                bus.cap_valid <= 1'b0;
                bus.overrun   <= 1'b0;
            end
        end
    end

`ifdef PCAP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.timeout <= 1'b0;
        else
            bus.timeout <= timeout_n;
    end
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
